// File: rtl/scan_frame_decoder_pkg.sv
// Shared constants and types for the scan-bus frame decoder.
// Segment patterns are bit6=a .. bit0=g, 1 = lit.
package scan_decode_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [0:0] state_t;

  localparam state_t HUNT    = 1'b0;
  localparam state_t COLLECT = 1'b1;

  localparam logic [2:0] SEL_FIRST = 3'd0;
  localparam logic [2:0] SEL_LAST  = 3'd5;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  // Seconds units and minute units can never be out of range, so they are not inspected.
  function automatic logic frame_in_range(input digit_t hh, input digit_t hl,
                                          input digit_t mh, input digit_t sh);
    return (hh <= 4'd2) && ((hh != 4'd2) || (hl <= 4'd3)) &&
           (mh <= 4'd5) && (sh <= 4'd5);
  endfunction

endpackage

// File: rtl/scan_frame_decoder_if.sv
// Scan-bus sample inputs and decoded frame outputs of scan_frame_decoder.
interface scan_frame_decoder_if #(parameter int CNT_W = 8);

  logic             ena;
  logic [6:0]       seg_in;
  logic [2:0]       sel_in;
  logic             err_clr;
  logic [23:0]      time_bcd;
  logic             frame_valid;
  logic             locked;
  logic             seg_err;
  logic             seq_err;
  logic             range_err;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output ena, seg_in, sel_in, err_clr,
    input  time_bcd, frame_valid, locked, seg_err, seq_err, range_err, frame_cnt
  );

  modport slave (
    input  ena, seg_in, sel_in, err_clr,
    output time_bcd, frame_valid, locked, seg_err, seq_err, range_err, frame_cnt
  );

endinterface

// File: rtl/scan_frame_decoder_seg7_to_bcd.sv
// Combinational 7-segment to BCD decoder; unknown patterns decode to 0 with illegal set.
module seg7_to_bcd
  import scan_decode_pkg::*;
(
  input  logic [6:0] seg,
  output digit_t     bcd,
  output logic       illegal
);

  always_comb begin
    bcd     = 4'd0;
    illegal = 1'b0;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/scan_frame_decoder.sv
// Reassembles scanned 7-segment digits Hh..Sl into a registered BCD time frame.
// Optional SCAN_RANGE_CHECK_EN rejects frames that are not a valid 24h time.
module scan_frame_decoder
  import scan_decode_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 clk_scan_to_light,
  input  logic                 rst,
  scan_frame_decoder_if.slave  bus
);

  digit_t           digit;
  logic             illegal;
  logic             range_ok;
  logic [23:0]      assembled;

  state_t           state_q,     state_d;
  logic [2:0]       exp_idx_q,   exp_idx_d;
  digit_t           frame_buf_q [5];
  digit_t           frame_buf_d [5];
  logic             bad_q,       bad_d;
  logic [3:0]       good_run_q,  good_run_d;
  logic             locked_q,    locked_d;
  logic [23:0]      time_q,      time_d;
  logic             fv_q,        fv_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             seg_err_q,   seg_err_d;
  logic             seq_err_q,   seq_err_d;
  logic             range_err_q, range_err_d;

  seg7_to_bcd u_seg7_to_bcd (
    .seg     (bus.seg_in),
    .bcd     (digit),
    .illegal (illegal)
  );

  assign assembled = {frame_buf_q[0], frame_buf_q[1], frame_buf_q[2],
                      frame_buf_q[3], frame_buf_q[4], digit};

`ifdef SCAN_RANGE_CHECK_EN
  assign range_ok = frame_in_range(frame_buf_q[0], frame_buf_q[1], frame_buf_q[2], frame_buf_q[4]);
`else
  // With the check compiled out range_err can never set and stays at its reset value of 0.
  assign range_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    exp_idx_d   = exp_idx_q;
    frame_buf_d = frame_buf_q;
    bad_d       = bad_q;
    good_run_d  = good_run_q;
    locked_d    = locked_q;
    time_d      = time_q;
    fv_d        = 1'b0;
    cnt_d       = cnt_q;
    seg_err_d   = seg_err_q;
    seq_err_d   = seq_err_q;
    range_err_d = range_err_q;

    if (bus.ena) begin
      // Clear first so that an error detected on the same edge wins.
      if (bus.err_clr) begin
        seg_err_d   = 1'b0;
        seq_err_d   = 1'b0;
        range_err_d = 1'b0;
      end
      if (bus.sel_in > SEL_LAST) seq_err_d = 1'b1;

      case (state_q)
        HUNT: begin
          if (bus.sel_in == SEL_FIRST) begin
            frame_buf_d[0] = digit;
            exp_idx_d      = 3'd1;
            bad_d          = illegal;
            if (illegal) seg_err_d = 1'b1;
            state_d        = COLLECT;
          end
        end
        COLLECT: begin
          if (bus.sel_in == exp_idx_q) begin
            if (illegal) begin
              bad_d     = 1'b1;
              seg_err_d = 1'b1;
            end
            if (exp_idx_q < SEL_LAST) begin
              frame_buf_d[exp_idx_q] = digit;
              exp_idx_d              = exp_idx_q + 3'd1;
            end else begin
              state_d = HUNT;
              if (!bad_q && !illegal && range_ok) begin
                time_d = assembled;
                fv_d   = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (good_run_q < 4'(LOCK_FRAMES)) good_run_d = good_run_q + 4'd1;
                locked_d = (good_run_d == 4'(LOCK_FRAMES));
              end else begin
                good_run_d = 4'd0;
                locked_d   = 1'b0;
                if (!range_ok) range_err_d = 1'b1;
              end
            end
          end else begin
            seq_err_d  = 1'b1;
            good_run_d = 4'd0;
            locked_d   = 1'b0;
            // A fresh select 0 restarts the frame immediately rather than waiting in HUNT.
            if (bus.sel_in == SEL_FIRST) begin
              frame_buf_d[0] = digit;
              exp_idx_d      = 3'd1;
              bad_d          = illegal;
              if (illegal) seg_err_d = 1'b1;
            end else begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_scan_to_light or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      exp_idx_q   <= 3'd0;
      frame_buf_q <= '{default: 4'd0};
      bad_q       <= 1'b0;
      good_run_q  <= 4'd0;
      locked_q    <= 1'b0;
      time_q      <= 24'd0;
      fv_q        <= 1'b0;
      cnt_q       <= '0;
      seg_err_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_idx_q   <= exp_idx_d;
      frame_buf_q <= frame_buf_d;
      bad_q       <= bad_d;
      good_run_q  <= good_run_d;
      locked_q    <= locked_d;
      time_q      <= time_d;
      fv_q        <= fv_d;
      cnt_q       <= cnt_d;
      seg_err_q   <= seg_err_d;
      seq_err_q   <= seq_err_d;
      range_err_q <= range_err_d;
    end
  end

  assign bus.time_bcd    = time_q;
  assign bus.frame_valid = fv_q;
  assign bus.locked      = locked_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.range_err   = range_err_q;
  assign bus.frame_cnt   = cnt_q;

endmodule

// File: tb/tb_scan_frame_decoder.sv
// Scoreboard bench for scan_frame_decoder; expected frames are queued as each scan is driven.
// Honours SCAN_RANGE_CHECK_EN for the out-of-range frame case.
module tb_scan_frame_decoder;

  typedef struct packed {
    logic [23:0] time_bcd;
    logic [7:0]  cnt;
  } frame_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [7:0] exp_cnt;
  logic fv_prev;
  frame_t sb[$];

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  scan_frame_decoder_if #(.CNT_W(8)) bus ();

  scan_frame_decoder #(.CNT_W(8), .LOCK_FRAMES(2)) dut (
    .clk_scan_to_light (clk),
    .rst               (rst),
    .bus               (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] seg, input logic [2:0] sel);
    bus.seg_in = seg;
    bus.sel_in = sel;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scans one frame; bad_idx < 6 replaces that digit with an unlit-except-g pattern.
  task automatic scanFrame(input logic [23:0] t, input bit commit, input int bad_idx);
    frame_t e;
    for (int i = 0; i < 6; i++) begin
      if (i == 5 && commit) begin
        exp_cnt = exp_cnt + 8'd1;
        e.time_bcd = t;
        e.cnt = exp_cnt;
        sb.push_back(e);
      end
      if (i == bad_idx) applyStimulus(7'b0000001, 3'(i));
      else              applyStimulus(seg_tab[t[4*(5-i) +: 4]], 3'(i));
    end
  endtask

  // Commit monitor: every frame_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    frame_t e;
    if (bus.frame_valid) begin
      if (fv_prev) checkOutput("fv_width", 32'd2, 32'd1);
      if (sb.size() == 0) begin
        checkOutput("unexpected_frame_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_time_bcd", {8'd0, bus.time_bcd}, {8'd0, e.time_bcd});
        checkOutput("sb_frame_cnt", {24'd0, bus.frame_cnt}, {24'd0, e.cnt});
      end
    end
    fv_prev <= bus.frame_valid;
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_cnt = 8'd0;
    fv_prev = 1'b0;
    rst = 1'b1;
    bus.ena = 1'b0;
    bus.seg_in = 7'd0;
    bus.sel_in = 3'd0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_time_bcd", {8'd0, bus.time_bcd}, 32'd0);
    checkOutput("rst_frame_valid", {31'd0, bus.frame_valid}, 32'd0);
    checkOutput("rst_locked", {31'd0, bus.locked}, 32'd0);
    checkOutput("rst_errs", {29'd0, bus.seg_err, bus.seq_err, bus.range_err}, 32'd0);
    checkOutput("rst_frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);

    $display("[TB] basic frames and lock");
    bus.ena = 1'b1;
    scanFrame(24'h123456, 1'b1, 6);
    checkOutput("f1_time_bcd", {8'd0, bus.time_bcd}, 32'h123456);
    checkOutput("f1_locked", {31'd0, bus.locked}, 32'd0);
    scanFrame(24'h654321, 1'b1, 6);
    checkOutput("f2_locked", {31'd0, bus.locked}, 32'd1);
    checkOutput("f2_frame_cnt", {24'd0, bus.frame_cnt}, 32'd2);

    $display("[TB] out-of-order select");
    applyStimulus(seg_tab[9], 3'd0);
    applyStimulus(seg_tab[8], 3'd1);
    applyStimulus(seg_tab[7], 3'd3);
    checkOutput("seq_err_set", {31'd0, bus.seq_err}, 32'd1);
    checkOutput("seq_locked", {31'd0, bus.locked}, 32'd0);
    checkOutput("seq_time_hold", {8'd0, bus.time_bcd}, 32'h654321);
    bus.err_clr = 1'b1;
    applyStimulus(seg_tab[0], 3'd3);
    bus.err_clr = 1'b0;
    checkOutput("seq_err_clr", {31'd0, bus.seq_err}, 32'd0);

    $display("[TB] illegal segment pattern");
    scanFrame(24'h121212, 1'b0, 2);
    checkOutput("seg_err_set", {31'd0, bus.seg_err}, 32'd1);
    checkOutput("seg_no_fv", {31'd0, bus.frame_valid}, 32'd0);
    checkOutput("seg_time_hold", {8'd0, bus.time_bcd}, 32'h654321);
    bus.err_clr = 1'b1;
    applyStimulus(seg_tab[0], 3'd3);
    bus.err_clr = 1'b0;
    checkOutput("seg_err_clr", {31'd0, bus.seg_err}, 32'd0);

    $display("[TB] start mid-scan");
    applyStimulus(seg_tab[1], 3'd3);
    applyStimulus(seg_tab[1], 3'd4);
    applyStimulus(seg_tab[1], 3'd5);
    checkOutput("mid_no_commit", {24'd0, bus.frame_cnt}, 32'd2);
    scanFrame(24'h235959, 1'b1, 6);
    checkOutput("mid_seq_err", {31'd0, bus.seq_err}, 32'd0);
    checkOutput("mid_time_bcd", {8'd0, bus.time_bcd}, 32'h235959);

    $display("[TB] enable pause");
    applyStimulus(seg_tab[0], 3'd0);
    applyStimulus(seg_tab[1], 3'd1);
    applyStimulus(seg_tab[0], 3'd2);
    bus.ena = 1'b0;
    applyStimulus(seg_tab[2], 3'd3);
    applyStimulus(seg_tab[2], 3'd3);
    applyStimulus(seg_tab[2], 3'd3);
    checkOutput("pause_time_hold", {8'd0, bus.time_bcd}, 32'h235959);
    checkOutput("pause_seq_err", {31'd0, bus.seq_err}, 32'd0);
    bus.ena = 1'b1;
    applyStimulus(seg_tab[2], 3'd3);
    applyStimulus(seg_tab[0], 3'd4);
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back('{time_bcd: 24'h010203, cnt: exp_cnt});
    applyStimulus(seg_tab[3], 3'd5);
    checkOutput("pause_time_bcd", {8'd0, bus.time_bcd}, 32'h010203);
    checkOutput("pause_locked", {31'd0, bus.locked}, 32'd1);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 4; i++) applyStimulus(seg_tab[1], 3'(i));
    bus.seg_in = seg_tab[1];
    bus.sel_in = 3'd4;
    #2 rst = 1'b1;
    #1;
    checkOutput("mrst_time_bcd", {8'd0, bus.time_bcd}, 32'd0);
    checkOutput("mrst_locked", {31'd0, bus.locked}, 32'd0);
    checkOutput("mrst_frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
    checkOutput("mrst_fv", {31'd0, bus.frame_valid}, 32'd0);
    checkOutput("mrst_pending", sb.size(), 32'd0);
    exp_cnt = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i < 6; i++) applyStimulus(seg_tab[1], 3'(i));
    checkOutput("mrst_hunt_seq", {31'd0, bus.seq_err}, 32'd0);
    checkOutput("mrst_hunt_cnt", {24'd0, bus.frame_cnt}, 32'd0);

    $display("[TB] range boundary");
`ifdef SCAN_RANGE_CHECK_EN
    scanFrame(24'h250000, 1'b0, 6);
    checkOutput("range_err", {31'd0, bus.range_err}, 32'd1);
    checkOutput("range_time_hold", {8'd0, bus.time_bcd}, 32'd0);
`else
    scanFrame(24'h250000, 1'b1, 6);
    checkOutput("range_err", {31'd0, bus.range_err}, 32'd0);
    checkOutput("range_time_bcd", {8'd0, bus.time_bcd}, 32'h250000);
`endif

    $display("[TB] illegal selects");
    applyStimulus(seg_tab[0], 3'd6);
    checkOutput("sel6_seq_err", {31'd0, bus.seq_err}, 32'd1);
    bus.err_clr = 1'b1;
    applyStimulus(seg_tab[0], 3'd7);
    bus.err_clr = 1'b0;
    checkOutput("sel7_set_wins", {31'd0, bus.seq_err}, 32'd1);

    repeat (2) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
